add_sub_pipe: RTL

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

---
 rtl/add_sub_pkg.sv | 15 +
 rtl/add_chunk.sv | 32 +++
 rtl/add_sub_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared defaults and per-stage control record for the segmented add/sub pipeline.
package add_sub_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Control half of a stage register. The operand/result slices live beside it
    // in the stage because their widths shrink/grow with the stage index.
    typedef struct packed {
        logic vld;
        logic carry;
        logic mode;
    } stage_ctl_t;

endpackage

// File: rtl/add_chunk.sv
// Purpose: CHUNK-bit ripple-carry segment with carry-out and carry into its MSB.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module add_chunk
    import add_sub_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < CHUNK; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = c[CHUNK];
    assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Purpose: add/subtract with the carry chain split into CHUNK-bit segments, one per stage.
// Latency: WIDTH/CHUNK cycles; one beat per cycle sustained.
// Backpressure: per-stage valid; a stage moves when empty or its successor moves.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("add_sub_pipe: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Stage k adds chunk k and loads register k. ad_* carries finished result
    // chunks below bit LO and still-unconsumed operand a at and above it.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK;

        stage_ctl_t        ctl_in;
        logic [WIDTH-1:0]  ad_in;
        logic [WIDTH-1:LO] b_in;
        logic [CHUNK-1:0]  b_eff;
        logic [CHUNK-1:0]  s_chunk;
        logic              c_out;
        logic              c_msb;
        logic [WIDTH-1:0]  ad_d;
        logic              vld;
        logic              adv;
        logic              nxt_adv;

        if (k == 0) begin : g_src
            // Subtract is a + ~b + 1, so the forced carry-in supplies the +1.
            assign ctl_in = '{vld: in_valid, carry: sub | cin, mode: sub};
            assign ad_in  = a;
            assign b_in   = b;
        end else begin : g_src
            assign ctl_in = stg[k-1].g_reg.ctl_q;
            assign ad_in  = stg[k-1].g_reg.ad_q;
            assign b_in   = stg[k-1].g_reg.b_q;
        end

        assign b_eff = ctl_in.mode ? ~b_in[LO +: CHUNK] : b_in[LO +: CHUNK];

        add_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a_i     (ad_in[LO +: CHUNK]),
            .b_i     (b_eff),
            .c_i     (ctl_in.carry),
            .s_o     (s_chunk),
            .c_o     (c_out),
            .c_msb_o (c_msb)
        );

        always_comb begin
            ad_d              = ad_in;
            ad_d[LO +: CHUNK] = s_chunk;
        end

        if (k == STAGES - 1) begin : g_nxt
            assign nxt_adv = out_ready;
        end else begin : g_nxt
            assign nxt_adv = stg[k+1].adv;
        end

        assign adv = !vld || nxt_adv;

        if (k < STAGES - 1) begin : g_reg
            stage_ctl_t        ctl_q;
            logic [WIDTH-1:0]  ad_q;
            logic [WIDTH-1:HI] b_q;
            logic              unused_msb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctl_q <= '0;
                    ad_q  <= '0;
                    b_q   <= '0;
                end else if (adv) begin
                    ctl_q.vld <= ctl_in.vld;
                    if (ctl_in.vld) begin
                        ctl_q.carry <= c_out;
                        ctl_q.mode  <= ctl_in.mode;
                        ad_q        <= ad_d;
                        b_q         <= b_in[WIDTH-1:HI];
                    end
                end
            end

            assign vld        = ctl_q.vld;
            assign unused_msb = c_msb;
        end else begin : g_out
            logic             vld_q;
            logic [WIDTH-1:0] sum_q;
            logic             co_q;
            logic             ovf_q;

            // Signed overflow is the disagreement of the carries into and out of the MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    sum_q <= '0;
                    co_q  <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    vld_q <= ctl_in.vld;
                    if (ctl_in.vld) begin
                        sum_q <= ad_d;
                        co_q  <= c_out;
                        ovf_q <= c_out ^ c_msb;
                    end
                end
            end

            assign vld = vld_q;
        end
    end

    assign in_ready  = stg[0].adv;
    assign out_valid = stg[STAGES-1].g_out.vld_q;
    assign sum       = stg[STAGES-1].g_out.sum_q;
    assign co        = stg[STAGES-1].g_out.co_q;
    assign ovf       = stg[STAGES-1].g_out.ovf_q;

endmodule
